// File: rtl/dequant_dezigzag.sv
// -----------------------------------------------------------------------------
// dequant_dezigzag
//   Takes one 64-coefficient block in zigzag order and multiplies each
//   coefficient by its quant-table entry. The products are saturated to 16 bits
//   and written out in natural (row-major 8x8) order. The block is then held
//   for the IDCT stage. The design uses one shared multiplier and handles one
//   coefficient per cycle. FSM: IDLE -> DEQ (64 cycles) -> DONE -> IDLE.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   data_in    [64][12] signed coefficients, index = zigzag position
//   valid_in   data_in holds a complete block
//   ready_in   block accepted on valid_in && ready_in
//   qt_wr_en   quant-table write strobe (honoured in IDLE only)
//   qt_addr    quant-table index, zigzag order
//   qt_data    quant-table value, unsigned
//   data_out   [64][16] signed dequantized block, index = row*8+col
//   valid_out  data_out complete and stable
//   ready_out  consumer takes the block on valid_out && ready_out
//   busy       high in DEQ or DONE
// -----------------------------------------------------------------------------
module dequant_dezigzag #(
    localparam int BLOCK_SIZE = 64,
    localparam int IN_W       = 12,
    localparam int Q_W        = 8,
    localparam int OUT_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BLOCK_SIZE-1:0][IN_W-1:0]     data_in,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic                                qt_wr_en,
    input  logic [5:0]                          qt_addr,
    input  logic [Q_W-1:0]                      qt_data,
    output logic [BLOCK_SIZE-1:0][OUT_W-1:0]    data_out,
    output logic                                valid_out,
    input  logic                                ready_out,
    output logic                                busy
);

    localparam int PROD_W = IN_W + Q_W + 1;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

    // Zigzag position -> natural (row*8+col) index.
    localparam logic [5:0] ZZ [BLOCK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                             state_q;
    logic [5:0]                         idx_q;
    logic [BLOCK_SIZE-1:0][IN_W-1:0]    coef_q;
    logic [Q_W-1:0]                     qt_q [BLOCK_SIZE];
    logic [BLOCK_SIZE-1:0][OUT_W-1:0]   data_out_q;
    logic                               ready_in_q;
    logic                               valid_out_q;
    logic                               busy_q;

    logic signed [PROD_W-1:0]           prod;
    logic [OUT_W-1:0]                   deq_d;

    // Shared multiplier: the quant entry is zero-extended so the signed product is exact.
    // NOTE: combinational logic uses blocking assignments and gives every output a value
    // on every path, so no latch is inferred.
    always_comb begin
        prod  = PROD_W'($signed(coef_q[idx_q])) * PROD_W'($signed({1'b0, qt_q[idx_q]}));
        deq_d = prod[OUT_W-1:0];
        if (prod > SAT_MAX) begin
            deq_d = 16'h7FFF;
        end else if (prod < SAT_MIN) begin
            deq_d = 16'h8000;
        end
    end

    // NOTE: coef_q has no reset. Every accept reloads it before DEQ reads it, so its
    // reset value is never observed.
    always_ff @(posedge clk) begin
        if (valid_in && ready_in_q) begin
            coef_q <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. The quant table is
    // reset with the rest of the state because every reset must restore pass-through
    // (all ones).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_out_q  <= '0;
            ready_in_q  <= 1'b1;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                qt_q[i] <= Q_W'(1);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // A write on the accepting edge lands before DEQ reads the table.
                    if (qt_wr_en) begin
                        qt_q[qt_addr] <= qt_data;
                    end
                    if (valid_in) begin
                        state_q    <= DEQ;
                        idx_q      <= '0;
                        ready_in_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                DEQ: begin
                    data_out_q[ZZ[idx_q]] <= deq_d;
                    idx_q                 <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_q     <= DONE;
                        valid_out_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_out) begin
                        state_q     <= IDLE;
                        valid_out_q <= 1'b0;
                        ready_in_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    valid_out_q <= 1'b0;
                    ready_in_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign ready_in  = ready_in_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dequant_dezigzag.sv
// -----------------------------------------------------------------------------
// tb_dequant_dezigzag
//   Directed bench for dequant_dezigzag. All expected values are hand-computed.
//   Stimulus changes 1 time unit after a rising edge. Outputs are sampled at
//   that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_dequant_dezigzag;

    logic                clk = 1'b0;
    logic                rst;
    logic [63:0][11:0]   data_in;
    logic                valid_in;
    logic                ready_in;
    logic                qt_wr_en;
    logic [5:0]          qt_addr;
    logic [7:0]          qt_data;
    logic [63:0][15:0]   data_out;
    logic                valid_out;
    logic                ready_out;
    logic                busy;

    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  cyc;
    logic signed [15:0]  exp_blk [64];
    logic [63:0][11:0]   blk;

    always #5 clk = ~clk;

    dequant_dezigzag dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .qt_wr_en  (qt_wr_en),
        .qt_addr   (qt_addr),
        .qt_data   (qt_data),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_blk[i] = '0;
    endtask

    task automatic check_block(input string tag);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s[%0d]", tag, i), $signed(data_out[i]), exp_blk[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic qt_write(input logic [5:0] a, input logic [7:0] d);
        qt_wr_en = 1'b1;
        qt_addr  = a;
        qt_data  = d;
        step();
        qt_wr_en = 1'b0;
    endtask

    // Presents a block and returns just after the accepting edge.
    task automatic send_block(input logic [63:0][11:0] b);
        int n;
        data_in  = b;
        valid_in = 1'b1;
        n = 0;
        while (ready_in !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("accept_bound", 32'(n < 200), 1);
        step();
        valid_in = 1'b0;
        qt_wr_en = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid_out !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic hand_off();
        ready_out = 1'b1;
        step();
        ready_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        data_in   = '0;
        valid_in  = 1'b0;
        qt_wr_en  = 1'b0;
        qt_addr   = '0;
        qt_data   = '0;
        ready_out = 1'b0;

        // Reset state
        #12;
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_ready_in",  32'(ready_in),  1);
        check("rst_busy",      32'(busy),      0);
        clear_exp();
        check_block("rst_data");
        @(negedge clk) rst = 1'b1;
        step();

        // Test 1: default table, exact 64-edge latency
        blk = '0;
        blk[0] = 12'd511;
        blk[1] = 12'hFFF;
        blk[2] = 12'd5;
        send_block(blk);
        check("t1_busy_deq",  32'(busy),     1);
        check("t1_ready_deq", 32'(ready_in), 0);
        wait_valid(cyc);
        check("t1_latency", cyc, 64);
        clear_exp();
        exp_blk[0] = 16'sd511;
        exp_blk[1] = -16'sd1;
        exp_blk[8] = 16'sd5;
        check_block("t1");
        hand_off();
        check("t1_valid_after", 32'(valid_out), 0);
        check("t1_ready_after", 32'(ready_in),  1);
        check("t1_busy_after",  32'(busy),      0);

        // Test 2: quant-table writes in IDLE
        qt_write(6'd0, 8'd16);
        qt_write(6'd2, 8'd2);
        blk = '0;
        blk[0] = 12'(-100);
        blk[2] = 12'(-511);
        send_block(blk);
        wait_valid(cyc);
        check("t2_latency", cyc, 64);
        clear_exp();
        exp_blk[0] = -16'sd1600;
        exp_blk[8] = -16'sd1022;
        check_block("t2");
        hand_off();

        // Test 3a: write coincident with accept, positive saturation
        qt_wr_en = 1'b1;
        qt_addr  = 6'd5;
        qt_data  = 8'd255;
        blk = '0;
        blk[5] = 12'd2047;
        send_block(blk);
        wait_valid(cyc);
        clear_exp();
        exp_blk[2] = 16'sd32767;
        check_block("t3a");
        hand_off();

        // Test 3b: negative saturation, in-range values, q=0
        qt_write(6'd1, 8'd0);
        blk = '0;
        blk[5] = 12'h800;
        blk[1] = 12'd100;
        blk[2] = 12'd7;
        blk[3] = 12'(-3);
        send_block(blk);
        wait_valid(cyc);
        clear_exp();
        exp_blk[2]  = -16'sd32768;
        exp_blk[1]  = 16'sd0;
        exp_blk[8]  = 16'sd14;
        exp_blk[16] = -16'sd3;
        check_block("t3b");
        hand_off();

        // Test 4: DONE held with ready_out low, valid_in pulsed and ignored
        blk = '0;
        blk[0]  = 12'd1;
        blk[63] = 12'(-7);
        send_block(blk);
        wait_valid(cyc);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                blk = '0;
                blk[0] = 12'd100;
                data_in  = blk;
                valid_in = 1'b1;
            end
            if (i == 4) valid_in = 1'b0;
            step();
            check("t4_hold_ready_in",  32'(ready_in),  0);
            check("t4_hold_valid_out", 32'(valid_out), 1);
            check("t4_hold_d0",  $signed(data_out[0]),  16);
            check("t4_hold_d63", $signed(data_out[63]), -7);
        end
        blk = '0;
        blk[0]    = 12'd3;
        data_in   = blk;
        valid_in  = 1'b1;
        ready_out = 1'b1;
        step();
        ready_out = 1'b0;
        check("t4_release_valid", 32'(valid_out), 0);
        check("t4_release_ready", 32'(ready_in),  1);
        check("t4_release_busy",  32'(busy),      0);
        step();
        valid_in = 1'b0;
        check("t4_next_accept_ready", 32'(ready_in), 0);
        check("t4_next_accept_busy",  32'(busy),     1);

        // Test 5: asynchronous reset at idx=30
        for (int i = 0; i < 30; i++) step();
        check("t5_partial_d0", $signed(data_out[0]), 48);
        #2 rst = 1'b0;
        #1;
        check("t5_valid_out", 32'(valid_out), 0);
        check("t5_ready_in",  32'(ready_in),  1);
        check("t5_busy",      32'(busy),      0);
        clear_exp();
        check_block("t5_data");
        @(negedge clk) rst = 1'b1;
        step();
        blk = '0;
        blk[0] = 12'd511;
        blk[1] = 12'hFFF;
        blk[2] = 12'd5;
        send_block(blk);
        wait_valid(cyc);
        check("t5_rerun_latency", cyc, 64);
        clear_exp();
        exp_blk[0] = 16'sd511;
        exp_blk[1] = -16'sd1;
        exp_blk[8] = 16'sd5;
        check_block("t5_rerun");
        hand_off();

        // Test 6: quant write during DEQ is dropped
        blk = '0;
        blk[0] = 12'd3;
        send_block(blk);
        for (int i = 0; i < 5; i++) step();
        qt_write(6'd0, 8'd4);
        wait_valid(cyc);
        check("t6_blk1_d0", $signed(data_out[0]), 3);
        hand_off();
        send_block(blk);
        wait_valid(cyc);
        check("t6_blk2_latency", cyc, 64);
        check("t6_blk2_d0", $signed(data_out[0]), 3);
        hand_off();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
